axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_pkg.sv | 25 ++
 rtl/axi_rd_arbiter_rr_arb2.sv | 40 ++++
 rtl/axi_rd_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI definitions for the instruction/data cache read arbiter.
// Holds the arbiter FSM state encoding, the AXI burst and response
// encodings, and the requester index constants, so the top level and the
// round-robin sub-module agree on what "index 0" and "index 1" mean.
package axi_rd_arbiter_pkg;

  // One outstanding AXI read: accept a request, issue AR, stream R beats
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic RQ_ICACHE = 1'b0;
  localparam logic RQ_DCACHE = 1'b1;

  // The requester index doubles as the AXI transaction id
  function automatic logic [3:0] rq_to_id(input logic idx);
    return {3'b000, idx};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin arbiter used by axi_rd_arbiter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req[1:0]   : request vector (already qualified by the caller)
//   advance    : a grant was taken this cycle; move the priority pointer
//   grant[1:0] : one-hot grant (all zero when nothing is requested)
module rr_arb2
  import axi_rd_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index that wins when both requesters ask in the same cycle
  logic ptr_q;

  // Contention goes to the pointer; a lone request always wins
  always_comb begin
    grant = 2'b00;
    if (req[0] && req[1]) begin
      grant[ptr_q] = 1'b1;
    end else begin
      grant = req;
    end
  end

  // After any grant, favour the requester that was not served; the dcache
  // is favoured out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= RQ_DCACHE;
    end else if (advance) begin
      ptr_q <= grant[0] ? RQ_DCACHE : RQ_ICACHE;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates icache (rq0) and dcache (rq1) read bursts onto one AXI read
// port, one outstanding burst at a time, and routes R beats back to the
// requester that owns the burst.
// Ports:
//   aclk, aresetn              : clock, asynchronous active-low reset
//   rq{0,1}_valid/ready/addr/len/size : requester burst request
//   rs{0,1}_valid/data/last/err/ready : routed read beats
//   ar* / arready              : AXI read address channel
//   rid/rdata/rresp/rlast/rvalid/rready : AXI read data channel
//   stat_grant{0,1}            : accepted-request counters (wrap around)
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [7:0]        rq0_len,
  input  logic [2:0]        rq0_size,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [7:0]        rq1_len,
  input  logic [2:0]        rq1_size,
  output logic              rs0_valid,
  output logic [DATA_W-1:0] rs0_data,
  output logic              rs0_last,
  output logic              rs0_err,
  input  logic              rs0_ready,
  output logic              rs1_valid,
  output logic [DATA_W-1:0] rs1_data,
  output logic              rs1_last,
  output logic              rs1_err,
  input  logic              rs1_ready,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       stat_grant0,
  output logic [31:0]       stat_grant1
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic              id_q;
  logic [31:0]       grant_cnt0_q, grant_cnt1_q;
  logic [1:0]        arb_req, arb_grant;
  logic              rq_hs;
  logic              beat_err;

  // Requests are only considered while idle; the reset term keeps rq_ready
  // low while aresetn is asserted even though the FSM already sits in IDLE
  assign arb_req = {rq1_valid, rq0_valid} & {2{(state_q == ST_IDLE) && aresetn}};

  // The arbiter only grants valid requests and rq_ready is the grant itself,
  // so any grant is a completed request handshake
  assign rq_hs = |arb_grant;

  rr_arb2 u_rr_arb2 (
    .clk     (aclk),
    .rst_n   (aresetn),
    .req     (arb_req),
    .advance (rq_hs),
    .grant   (arb_grant)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst termination is by rlast alone; the beat count is never compared
  // against the requested length
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rq_hs) state_d = ST_ADDR;
      ST_ADDR: if (arready) state_d = ST_DATA;
      ST_DATA: if (rvalid && rready && rlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // AR fields come only from these registers, so they stay stable while
  // arvalid waits for arready
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      id_q   <= RQ_ICACHE;
    end else if (rq_hs) begin
      id_q <= arb_grant[1];
      if (arb_grant[1]) begin
        addr_q <= rq1_addr;
        len_q  <= rq1_len;
        size_q <= rq1_size;
      end else begin
        addr_q <= rq0_addr;
        len_q  <= rq0_len;
        size_q <= rq0_size;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (arb_grant[0]) grant_cnt0_q <= grant_cnt0_q + 32'd1;
      if (arb_grant[1]) grant_cnt1_q <= grant_cnt1_q + 32'd1;
    end
  end

  assign stat_grant0 = grant_cnt0_q;
  assign stat_grant1 = grant_cnt1_q;

  // A beat carrying a foreign rid still goes to the owner but is flagged
  always_comb begin
    rq0_ready = arb_grant[0];
    rq1_ready = arb_grant[1];
    arvalid   = 1'b0;
    arid      = '0;
    araddr    = '0;
    arlen     = '0;
    arsize    = '0;
    arburst   = '0;
    arlock    = '0;
    arcache   = '0;
    arprot    = '0;
    rready    = 1'b0;
    rs0_valid = 1'b0;
    rs0_data  = '0;
    rs0_last  = 1'b0;
    rs0_err   = 1'b0;
    rs1_valid = 1'b0;
    rs1_data  = '0;
    rs1_last  = 1'b0;
    rs1_err   = 1'b0;
    beat_err  = (rresp != AXI_RESP_OKAY) || (rid != rq_to_id(id_q));
    case (state_q)
      ST_ADDR: begin
        arvalid = 1'b1;
        arid    = rq_to_id(id_q);
        araddr  = addr_q;
        arlen   = len_q;
        arsize  = size_q;
        arburst = AXI_BURST_INCR;
      end
      ST_DATA: begin
        if (id_q == RQ_DCACHE) begin
          rs1_valid = rvalid;
          rs1_data  = rdata;
          rs1_last  = rlast;
          rs1_err   = beat_err;
          rready    = rs1_ready;
        end else begin
          rs0_valid = rvalid;
          rs0_data  = rdata;
          rs0_last  = rlast;
          rs0_err   = beat_err;
          rready    = rs0_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter. Requester drivers and an
// AXI slave model generate traffic; a transaction-level model predicts who
// is granted and what each AR and routed beat must look like.
module tb_axi_rd_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  localparam int N0 = 30;
  localparam int N1 = 30;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        rq0_valid, rq0_ready, rq1_valid, rq1_ready;
  logic [31:0] rq0_addr, rq1_addr;
  logic [7:0]  rq0_len, rq1_len;
  logic [2:0]  rq0_size, rq1_size;
  logic        rs0_valid, rs0_last, rs0_err, rs0_ready;
  logic        rs1_valid, rs1_last, rs1_err, rs1_ready;
  logic [31:0] rs0_data, rs1_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] stat_grant0, stat_grant1;

  int    checks = 0;
  int    fails = 0;
  bit    mon_en = 0;
  int    rs_mode = 0;
  int    beats_seen = 0;
  logic  busy = 0, addr_done = 0, cur_g = 0, last_g = 0;
  logic  g_new, exp_arv, in_data, exp_rr;
  logic [1:0] exp_rdy;
  ar_t   ar_new;
  beat_t bt;
  ar_t   ar_exp[$];
  ar_t   slv_q[$];
  beat_t rs_exp0[$];
  beat_t rs_exp1[$];

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_addr(rq0_addr),
    .rq0_len(rq0_len), .rq0_size(rq0_size),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_addr(rq1_addr),
    .rq1_len(rq1_len), .rq1_size(rq1_size),
    .rs0_valid(rs0_valid), .rs0_data(rs0_data), .rs0_last(rs0_last),
    .rs0_err(rs0_err), .rs0_ready(rs0_ready),
    .rs1_valid(rs1_valid), .rs1_data(rs1_data), .rs1_last(rs1_last),
    .rs1_err(rs1_err), .rs1_ready(rs1_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue n bursts from requester k, each held until it is accepted
  task automatic applyStimulus(input int k, input int n);
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    bit          hs;
    int          w;
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat ($urandom_range(0, 3)) tick();
      if (k == 0 && i == 0) begin
        a = 32'hBFC0_0000; l = 8'd7; s = 3'd2;
      end else begin
        a = $urandom & 32'hFFFF_FFFC;
        l = 8'($urandom_range(0, 5));
        s = 3'($urandom_range(0, 2));
      end
      if (k == 0) begin
        rq0_valid = 1'b1; rq0_addr = a; rq0_len = l; rq0_size = s;
      end else begin
        rq1_valid = 1'b1; rq1_addr = a; rq1_len = l; rq1_size = s;
      end
      hs = 0;
      w = 0;
      while (!hs && w < 500) begin
        @(negedge aclk);
        hs = (k == 0) ? rq0_ready : rq1_ready;
        tick();
        w++;
      end
      checkOutput(k == 0 ? "rq0_accepted" : "rq1_accepted", 64'(hs), 64'(1));
      if (k == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
    end
  endtask

  // Requester-side R ready: random, toggling every cycle, or held high
  initial begin
    rs0_ready = 1'b1;
    rs1_ready = 1'b1;
    forever begin
      tick();
      if (rs_mode == 1) begin
        rs0_ready = ~rs0_ready;
        rs1_ready = ~rs1_ready;
      end else if (rs_mode == 2) begin
        rs0_ready = 1'b1;
        rs1_ready = 1'b1;
      end else begin
        rs0_ready = ($urandom % 4) != 0;
        rs1_ready = ($urandom % 4) != 0;
      end
    end
  end

  // AXI slave: random AR stall, then len+1 beats with random gaps, errors
  // and occasional foreign rid; each driven beat is pushed to the owner's
  // expected queue
  initial begin
    ar_t t;
    bit  hs;
    bit  bad_id;
    int  w;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rdata = '0; rresp = '0; rid = '0;
    forever begin
      @(negedge aclk);
      if (arvalid && aresetn) begin
        tick();
        repeat ($urandom_range(0, 5)) tick();
        arready = 1'b1;
        hs = 0;
        w = 0;
        while (!hs && w < 200) begin
          @(negedge aclk); hs = arvalid; tick(); w++;
        end
        arready = 1'b0;
        checkOutput("ar_handshake_seen", 64'(slv_q.size() > 0), 64'(1));
        if (slv_q.size() > 0) begin
          t = slv_q.pop_front();
          for (int b = 0; b <= int'(t.len); b++) begin
            rvalid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            bad_id = ($urandom % 8) == 0;
            rdata  = $urandom;
            rresp  = (($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rid    = bad_id ? 4'($urandom_range(2, 15)) : {3'b000, t.id};
            rlast  = (b == int'(t.len));
            rvalid = 1'b1;
            bt.data = rdata;
            bt.last = rlast;
            bt.err  = (rresp != 2'b00) || bad_id;
            if (t.id) rs_exp1.push_back(bt); else rs_exp0.push_back(bt);
            hs = 0;
            w = 0;
            while (!hs && w < 200) begin
              @(negedge aclk); hs = rready; tick(); w++;
            end
          end
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
    end
  end

  // Monitor and transaction model: free -> address phase -> data phase
  always @(negedge aclk) begin
    if (mon_en) begin
      exp_rdy = 2'b00;
      g_new = 1'b0;
      if (!busy && (rq0_valid || rq1_valid)) begin
        g_new = (rq0_valid && rq1_valid) ? ~last_g : rq1_valid;
        exp_rdy[g_new] = 1'b1;
      end
      checkOutput("rq0_ready", 64'(rq0_ready), 64'(exp_rdy[0]));
      checkOutput("rq1_ready", 64'(rq1_ready), 64'(exp_rdy[1]));
      exp_arv = busy && !addr_done;
      checkOutput("arvalid", 64'(arvalid), 64'(exp_arv));
      if (exp_arv && ar_exp.size() > 0) begin
        checkOutput("arid", 64'(arid), 64'({3'b000, ar_exp[0].id}));
        checkOutput("araddr", 64'(araddr), 64'(ar_exp[0].addr));
        checkOutput("arlen", 64'(arlen), 64'(ar_exp[0].len));
        checkOutput("arsize", 64'(arsize), 64'(ar_exp[0].size));
        checkOutput("ar_fixed", 64'({arburst, arlock, arcache, arprot}), 64'({2'b01, 2'b00, 4'h0, 3'h0}));
      end
      in_data = busy && addr_done;
      exp_rr  = in_data && (cur_g ? rs1_ready : rs0_ready);
      checkOutput("rready", 64'(rready), 64'(exp_rr));
      checkOutput("rs0_valid", 64'(rs0_valid), 64'(in_data && !cur_g && rvalid));
      checkOutput("rs1_valid", 64'(rs1_valid), 64'(in_data && cur_g && rvalid));
      if (in_data && rvalid && exp_rr) begin
        beats_seen++;
        if (!cur_g) begin
          checkOutput("rs0_beat_expected", 64'(rs_exp0.size() > 0), 64'(1));
          if (rs_exp0.size() > 0) begin
            bt = rs_exp0.pop_front();
            checkOutput("rs0_data", 64'(rs0_data), 64'(bt.data));
            checkOutput("rs0_last", 64'(rs0_last), 64'(bt.last));
            checkOutput("rs0_err", 64'(rs0_err), 64'(bt.err));
          end
        end else begin
          checkOutput("rs1_beat_expected", 64'(rs_exp1.size() > 0), 64'(1));
          if (rs_exp1.size() > 0) begin
            bt = rs_exp1.pop_front();
            checkOutput("rs1_data", 64'(rs1_data), 64'(bt.data));
            checkOutput("rs1_last", 64'(rs1_last), 64'(bt.last));
            checkOutput("rs1_err", 64'(rs1_err), 64'(bt.err));
          end
        end
      end
      if (exp_rdy != 2'b00) begin
        busy = 1'b1;
        addr_done = 1'b0;
        cur_g = g_new;
        last_g = g_new;
        ar_new.id   = g_new;
        ar_new.addr = g_new ? rq1_addr : rq0_addr;
        ar_new.len  = g_new ? rq1_len : rq0_len;
        ar_new.size = g_new ? rq1_size : rq0_size;
        ar_exp.push_back(ar_new);
      end else if (exp_arv && arready) begin
        addr_done = 1'b1;
        if (ar_exp.size() > 0) slv_q.push_back(ar_exp.pop_front());
      end else if (in_data && rvalid && exp_rr && rlast) begin
        busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int b0;
    aresetn = 1'b0;
    rq0_valid = 1'b0; rq0_addr = '0; rq0_len = '0; rq0_size = '0;
    rq1_valid = 1'b0; rq1_addr = '0; rq1_len = '0; rq1_size = '0;
    repeat (3) @(negedge aclk);
    checkOutput("reset_arvalid", 64'(arvalid), 64'(0));
    checkOutput("reset_rready", 64'(rready), 64'(0));
    checkOutput("reset_stat", 64'({stat_grant0, stat_grant1}), 64'(0));
    aresetn = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    $display("[TB] random traffic phase");
    fork
      applyStimulus(0, N0);
      applyStimulus(1, N1);
      begin
        repeat (300) @(posedge aclk);
        rs_mode = 1;
      end
    join
    w = 0;
    while ((busy || ar_exp.size() != 0 || rs_exp0.size() != 0 || rs_exp1.size() != 0) && w < 20000) begin
      tick();
      w++;
    end
    checkOutput("traffic_drained", 64'(w < 20000), 64'(1));
    checkOutput("stat_grant0", 64'(stat_grant0), 64'(N0));
    checkOutput("stat_grant1", 64'(stat_grant1), 64'(N1));

    $display("[TB] reset during burst");
    rs_mode = 2;
    b0 = beats_seen;
    applyStimulus(0, 1);
    w = 0;
    while (beats_seen < b0 + 2 && w < 500) begin
      tick();
      w++;
    end
    checkOutput("burst_in_progress", 64'(beats_seen >= b0 + 2), 64'(1));
    mon_en = 1'b0;
    rq1_valid = 1'b1;
    #3;
    aresetn = 1'b0;
    #1;
    checkOutput("rst_arvalid", 64'(arvalid), 64'(0));
    checkOutput("rst_rready", 64'(rready), 64'(0));
    checkOutput("rst_rq_ready", 64'({rq0_ready, rq1_ready}), 64'(0));
    checkOutput("rst_rs_valid", 64'({rs0_valid, rs1_valid}), 64'(0));
    checkOutput("rst_ar_fields", 64'({arid, araddr, arlen}), 64'(0));
    checkOutput("rst_stat", 64'({stat_grant0, stat_grant1}), 64'(0));
    #2;
    aresetn = 1'b1;
    rq1_valid = 1'b0;
    tick();
    rq0_valid = 1'b1;
    rq1_valid = 1'b1;
    #1;
    checkOutput("post_rst_rq1_ready", 64'(rq1_ready), 64'(1));
    checkOutput("post_rst_rq0_ready", 64'(rq0_ready), 64'(0));
    tick();
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    #1;
    checkOutput("post_rst_arvalid", 64'(arvalid), 64'(1));
    checkOutput("post_rst_arid", 64'(arid), 64'(1));
    checkOutput("post_rst_stat", 64'({stat_grant0, stat_grant1}), 64'({32'd0, 32'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
